spi_reg_bridge: RTL

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_bridge_pkg.sv | 23 ++
 rtl/spi_reg_bridge_if.sv | 25 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_reg_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
//   state_e  : bridge FSM states
//   RW_BIT   : command bit selecting read (1) or write (0)
//   RSV_BIT  : reserved command bit; a set value makes the frame ignored
//   ADDR_W   : IO register address width
//   DATA_W   : data byte width
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_FETCH,
        RD_DATA,
        IGNORE
    } state_e;

    localparam int RW_BIT  = 7;
    localparam int RSV_BIT = 6;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Peripheral register bus between the bridge (master) and the IO registers (slave).
//   IO_Addr  : register address
//   dbus_out : write data, qualified by iowe
//   iowe     : one-cycle write strobe
//   iore     : one-cycle read strobe
//   dbus_in  : read data, valid the cycle after iore
interface spi_reg_bridge_if
    import spi_bridge_pkg::*;
();
    logic [ADDR_W-1:0] IO_Addr;
    logic [DATA_W-1:0] dbus_out;
    logic [DATA_W-1:0] dbus_in;
    logic              iowe;
    logic              iore;

    modport master (
        output IO_Addr, dbus_out, iowe, iore,
        input  dbus_in
    );

    modport slave (
        input  IO_Addr, dbus_out, iowe, iore,
        output dbus_in
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus edge detection.
//   clk_i   : sampling clock
//   rst_n_i : synchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized level
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns frames into IO register bus accesses.
// Frame: command byte {RW, reserved, addr[5:0]} followed by data bytes.
//   cp2      : system clock
//   ireset   : synchronous active-low reset
//   sck_i    : SPI clock (async, mode 0)
//   mosi_i   : SPI data in, MSB first
//   ss_i     : slave select, active low
//   miso_o   : SPI data out, MSB first
//   miso_oe  : MISO drive enable
//   busy     : FSM not idle
//   bus      : register bus (master side)
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_INC    = 1'b1
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             sck_i,
    input  logic             mosi_i,
    input  logic             ss_i,
    output logic             miso_o,
    output logic             miso_oe,
    output logic             busy,
    spi_reg_bridge_if.master bus
);

    localparam logic [1:0] WARM_DONE = 2'(SYNC_STAGES);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk_i(cp2), .rst_n_i(ireset), .d_i(sck_i),
        .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk_i(cp2), .rst_n_i(ireset), .d_i(mosi_i),
        .q_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk_i(cp2), .rst_n_i(ireset), .d_i(ss_i),
        .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    logic unused_edges;
    assign unused_edges = sck_lvl ^ mosi_rise ^ mosi_fall;

    state_e            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              iowe_q, iowe_d;
    logic              iore_q, iore_d;
    logic [1:0]        warm_q, warm_d;
    logic              armed_q, armed_d;

    logic              counting;
    logic              byte_done;
    logic [DATA_W-1:0] rx_shift;

    always_ff @(posedge cp2) begin
        if (!ireset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            iowe_q   <= 1'b0;
            iore_q   <= 1'b0;
            warm_q   <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            iowe_q   <= iowe_d;
            iore_q   <= iore_d;
            warm_q   <= warm_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        iowe_d   = 1'b0;
        iore_d   = 1'b0;

        // The synchronizer chain still holds reset values for SYNC_STAGES
        // cycles after reset. Only arm once it has flushed and SS is seen
        // high, so an SS held low across reset never starts a frame.
        warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == WARM_DONE) & ss_lvl);

        counting  = (state_q == CMD) || (state_q == WR_DATA) ||
                    (state_q == RD_FETCH) || (state_q == RD_DATA);
        rx_shift  = {rx_q[DATA_W-2:0], mosi_lvl};
        byte_done = counting && sck_rise && (bitcnt_q == 3'd7);

        if (counting && sck_rise) begin
            rx_d     = rx_shift;
            bitcnt_d = bitcnt_q + 3'd1;
        end

        // Write address advances the cycle after its iowe pulse.
        if (iowe_q && AUTO_INC)
            addr_d = addr_q + ADDR_W'(1);

        case (state_q)
            IDLE: begin
                tx_d = '0;
                if (ss_fall && armed_q) begin
                    state_d  = CMD;
                    bitcnt_d = '0;
                    rx_d     = '0;
                end
            end
            CMD: begin
                if (byte_done) begin
                    addr_d = rx_shift[ADDR_W-1:0];
                    if (rx_shift[RSV_BIT]) begin
                        state_d = IGNORE;
                    end else if (rx_shift[RW_BIT]) begin
                        state_d = RD_FETCH;
                        iore_d  = 1'b1;
                    end else begin
                        state_d = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (byte_done) begin
                    dout_d = rx_shift;
                    iowe_d = 1'b1;
                end
            end
            RD_FETCH: begin
                // First cycle here is the iore cycle; the second one sees
                // the returned data and preloads the MSB onto MISO.
                if (!iore_q) begin
                    tx_d    = bus.dbus_in;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                // The fall that follows a byte's 8th rise (bitcnt == 0) must
                // not shift: the next byte's MSB was already preloaded.
                if (sck_fall && (bitcnt_q != 3'd0))
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                if (byte_done) begin
                    if (AUTO_INC)
                        addr_d = addr_q + ADDR_W'(1);
                    state_d = RD_FETCH;
                    iore_d  = 1'b1;
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        // Deselect aborts the frame. A write byte completing in the same
        // cycle still gets its iowe; a read prefetch is dropped.
        if (ss_rise && (state_q != IDLE)) begin
            state_d  = IDLE;
            tx_d     = '0;
            bitcnt_d = '0;
            iore_d   = 1'b0;
        end
    end

    assign bus.IO_Addr  = addr_q;
    assign bus.dbus_out = dout_q;
    assign bus.iowe     = iowe_q;
    assign bus.iore     = iore_q;
    assign miso_o       = tx_q[DATA_W-1];
    assign miso_oe      = counting;
    assign busy         = (state_q != IDLE);

endmodule
